// File: rtl/conv_window_mac_if.sv
// Handshake/bus bundle between conv_controller (master) and conv_window_mac (slave).
interface conv_window_mac_if #(
  parameter int DATA_W  = 8,
  parameter int COEFF_W = 8,
  parameter int OUT_W   = 16
);
  logic [3*DATA_W-1:0]      sample_data;
  logic                     sample_stream;
  logic                     sample_shift;
  logic                     row_clear;
  logic [3*COEFF_W-1:0]     coeff_data;
  logic                     coeff_ld;
  logic [1:0]               coeff_sel;
  logic                     convolve_en;
  logic signed [OUT_W-1:0]  result;
  logic                     result_valid;
  logic                     result_sat;
  logic                     window_ready;
  logic                     busy;
  logic                     coeff_err;

  modport master (
    output sample_data, sample_stream, sample_shift, row_clear,
           coeff_data, coeff_ld, coeff_sel, convolve_en,
    input  result, result_valid, result_sat, window_ready, busy, coeff_err
  );

  modport slave (
    input  sample_data, sample_stream, sample_shift, row_clear,
           coeff_data, coeff_ld, coeff_sel, convolve_en,
    output result, result_valid, result_sat, window_ready, busy, coeff_err
  );
endinterface

// File: rtl/conv_window_mac.sv
// 3x3 sample window + coefficient bank feeding a 3-stage signed MAC pipeline
// (products -> row sums -> saturated total). One result per convolve_en, no stall.
module conv_window_mac #(
  parameter int DATA_W  = 8,
  parameter int COEFF_W = 8,
  parameter int ACC_W   = 20,
  parameter int OUT_W   = 16
) (
  input logic              clk,
  input logic              rst,
  conv_window_mac_if.slave bus
);
  localparam int PROD_W = DATA_W + COEFF_W + 1;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  // w[r][c]: c=2 is the newest column
  logic        [DATA_W-1:0]  r_win  [3][3];
  logic signed [COEFF_W-1:0] r_coef [3][3];
  logic        [1:0]         r_col_cnt;
  logic                      r_coeff_err;

  logic signed [PROD_W-1:0]  w_prod [3][3];
  logic signed [PROD_W-1:0]  r_prod [3][3];
  logic signed [ACC_W-1:0]   w_row  [3];
  logic signed [ACC_W-1:0]   r_row  [3];
  logic signed [ACC_W-1:0]   w_total;
  logic                      w_clip_hi;
  logic                      w_clip_lo;
  logic signed [OUT_W-1:0]   w_sat_val;
  logic                      r_v1, r_v2, r_v3;
  logic signed [OUT_W-1:0]   r_result;
  logic                      r_sat;

  // Window shift register and column counter; clear beats stream beats shift
  always_ff @(posedge clk) begin
    // NOTE: every sequential assignment uses <= so all registers update from pre-edge values.
    if (rst || bus.row_clear) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          r_win[r][c] <= '0;
      r_col_cnt <= '0;
    end else if (bus.sample_stream || bus.sample_shift) begin
      for (int r = 0; r < 3; r++) begin
        r_win[r][0] <= r_win[r][1];
        r_win[r][1] <= r_win[r][2];
        r_win[r][2] <= bus.sample_stream ? bus.sample_data[r*DATA_W +: DATA_W] : '0;
      end
      if (r_col_cnt != 2'd3)
        r_col_cnt <= r_col_cnt + 2'd1;
    end
  end

  // Coefficient bank writes; an illegal row select only raises the sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          r_coef[r][c] <= '0;
      r_coeff_err <= 1'b0;
    end else if (bus.coeff_ld) begin
      if (bus.coeff_sel == 2'd3)
        r_coeff_err <= 1'b1;
      for (int r = 0; r < 3; r++)
        if (bus.coeff_sel == 2'(r))
          for (int c = 0; c < 3; c++)
            r_coef[r][c] <= bus.coeff_data[c*COEFF_W +: COEFF_W];
    end
  end

  // Combinational products, row sums and saturation of the total
  always_comb begin
    // NOTE: each always_comb output gets a default first so no path can leave it latched.
    w_total = '0;
    for (int r = 0; r < 3; r++) begin
      w_row[r] = '0;
      for (int c = 0; c < 3; c++) begin
        w_prod[r][c] = PROD_W'($signed({1'b0, r_win[r][c]})) * PROD_W'(r_coef[r][c]);
        w_row[r]     = w_row[r] + ACC_W'(r_prod[r][c]);
      end
      w_total = w_total + r_row[r];
    end
    w_clip_hi = (w_total > SAT_MAX);
    w_clip_lo = (w_total < SAT_MIN);
    w_sat_val = w_clip_hi ? OUT_W'(SAT_MAX) :
                w_clip_lo ? OUT_W'(SAT_MIN) : w_total[OUT_W-1:0];
  end

  // Pipeline data registers for S1/S2
  always_ff @(posedge clk) begin
    // NOTE: datapath stages carry no reset; their contents are only consumed behind a valid bit.
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++)
        r_prod[r][c] <= w_prod[r][c];
      r_row[r] <= w_row[r];
    end
  end

  // Stage valids and the S3 output register; result holds between valid pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1     <= 1'b0;
      r_v2     <= 1'b0;
      r_v3     <= 1'b0;
      r_result <= '0;
      r_sat    <= 1'b0;
    end else begin
      r_v1  <= bus.convolve_en;
      r_v2  <= r_v1;
      r_v3  <= r_v2;
      r_sat <= r_v2 && (w_clip_hi || w_clip_lo);
      if (r_v2)
        r_result <= w_sat_val;
    end
  end

  assign bus.result       = r_result;
  assign bus.result_valid = r_v3;
  assign bus.result_sat   = r_sat;
  assign bus.window_ready = (r_col_cnt == 2'd3);
  assign bus.busy         = r_v1 || r_v2 || r_v3;
  assign bus.coeff_err    = r_coeff_err;
endmodule

// File: tb/tb_conv_window_mac.sv
// Directed, table-driven bench for conv_window_mac plus hand-written pipeline corner sequences.
module tb_conv_window_mac;
  localparam int DATA_W  = 8;
  localparam int COEFF_W = 8;
  localparam int OUT_W   = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_window_mac_if #(.DATA_W(DATA_W), .COEFF_W(COEFF_W), .OUT_W(OUT_W)) bus ();

  conv_window_mac #(.DATA_W(DATA_W), .COEFF_W(COEFF_W), .ACC_W(20), .OUT_W(OUT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string            name;
    logic [2:0][23:0] col;   // col[0] streamed first
    logic [2:0][23:0] krow;  // coefficient rows 0..2
    int               exp_res;
    bit               exp_sat;
  } vec_t;

  vec_t vecs [7];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] pack3(input int v0, input int v1, input int v2);
    return {8'(v2), 8'(v1), 8'(v0)};
  endfunction

  function automatic vec_t mk(input string n, input logic [23:0] c0, c1, c2,
                              input logic [23:0] k0, k1, k2, input int r, input bit s);
    vec_t v;
    v.name = n;
    v.col[0] = c0; v.col[1] = c1; v.col[2] = c2;
    v.krow[0] = k0; v.krow[1] = k1; v.krow[2] = k2;
    v.exp_res = r;
    v.exp_sat = s;
    return v;
  endfunction

  task automatic clear_strobes();
    bus.sample_stream = 1'b0;
    bus.sample_shift  = 1'b0;
    bus.row_clear     = 1'b0;
    bus.coeff_ld      = 1'b0;
    bus.convolve_en   = 1'b0;
  endtask

  task automatic load_kernel(input logic [2:0][23:0] k);
    for (int r = 0; r < 3; r++) begin
      bus.coeff_ld   = 1'b1;
      bus.coeff_sel  = 2'(r);
      bus.coeff_data = k[r];
      step();
    end
    bus.coeff_ld = 1'b0;
  endtask

  task automatic fill_window(input string name, input logic [2:0][23:0] c);
    bus.row_clear = 1'b1;
    step();
    bus.row_clear = 1'b0;
    check({name, ".ready_after_clear"}, bus.window_ready, 0);
    for (int i = 0; i < 3; i++) begin
      bus.sample_stream = 1'b1;
      bus.sample_data   = c[i];
      step();
    end
    bus.sample_stream = 1'b0;
    check({name, ".ready_full"}, bus.window_ready, 1);
  endtask

  // Pulse convolve_en (other strobes already set by the caller apply in the same cycle)
  task automatic run_conv(input string name, input int exp_res, input bit exp_sat);
    bus.convolve_en = 1'b1;
    step();
    clear_strobes();
    check({name, ".busy"}, bus.busy, 1);
    step();
    check({name, ".valid_early"}, bus.result_valid, 0);
    step();
    check({name, ".valid"}, bus.result_valid, 1);
    check({name, ".result"}, bus.result, exp_res);
    check({name, ".sat"}, bus.result_sat, exp_sat);
    step();
    check({name, ".valid_pulse"}, bus.result_valid, 0);
    check({name, ".sat_idle"}, bus.result_sat, 0);
    check({name, ".busy_done"}, bus.busy, 0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, ".result"}, bus.result, 0);
    check({name, ".valid"}, bus.result_valid, 0);
    check({name, ".sat"}, bus.result_sat, 0);
    check({name, ".ready"}, bus.window_ready, 0);
    check({name, ".busy"}, bus.busy, 0);
    check({name, ".coeff_err"}, bus.coeff_err, 0);
  endtask

  logic [2:0][23:0] k_ident, k_ones, c_123;
  int               busy_cnt, first_v, last_v;
  int               res_q [$];

  initial begin
    k_ident = {pack3(0, 0, 0), pack3(0, 1, 0), pack3(0, 0, 0)};
    k_ones  = {pack3(1, 1, 1), pack3(1, 1, 1), pack3(1, 1, 1)};
    c_123   = {pack3(7, 8, 9), pack3(4, 5, 6), pack3(1, 2, 3)};

    vecs[0] = mk("identity", pack3(1, 2, 3), pack3(4, 5, 6), pack3(7, 8, 9),
                 pack3(0, 0, 0), pack3(0, 1, 0), pack3(0, 0, 0), 5, 0);
    vecs[1] = mk("sat_pos", pack3(255, 255, 255), pack3(255, 255, 255), pack3(255, 255, 255),
                 pack3(127, 127, 127), pack3(127, 127, 127), pack3(127, 127, 127), 32767, 1);
    vecs[2] = mk("sat_neg", pack3(255, 255, 255), pack3(255, 255, 255), pack3(255, 255, 255),
                 pack3(-128, -128, -128), pack3(-128, -128, -128), pack3(-128, -128, -128),
                 -32768, 1);
    vecs[3] = mk("below_sat_pos", pack3(255, 255, 255), pack3(255, 255, 255), pack3(255, 255, 255),
                 pack3(14, 14, 14), pack3(14, 14, 14), pack3(14, 14, 14), 32130, 0);
    vecs[4] = mk("below_sat_neg", pack3(255, 255, 255), pack3(255, 255, 255), pack3(255, 255, 255),
                 pack3(-14, -14, -14), pack3(-14, -14, -14), pack3(-14, -14, -14), -32130, 0);
    vecs[5] = mk("laplace", pack3(0, 200, 0), pack3(9, 255, 3), pack3(0, 1, 0),
                 pack3(0, -1, 0), pack3(-1, 4, -1), pack3(0, -1, 0), 807, 0);
    vecs[6] = mk("mixed", pack3(10, 20, 30), pack3(1, 2, 3), pack3(100, 0, 255),
                 pack3(1, 2, 3), pack3(-4, -5, -6), pack3(7, 8, -9), -1839, 0);

    rst = 1'b1;
    bus.sample_data = '0;
    bus.coeff_data  = '0;
    bus.coeff_sel   = '0;
    clear_strobes();
    step();
    step();
    rst = 1'b0;
    check_all_zero("reset");

    // Table-driven convolutions
    foreach (vecs[i]) begin
      load_kernel(vecs[i].krow);
      fill_window(vecs[i].name, vecs[i].col);
      run_conv(vecs[i].name, vecs[i].exp_res, vecs[i].exp_sat);
    end
    check("table.coeff_err", bus.coeff_err, 0);

    // Illegal select leaves the bank alone; a same-cycle load only affects later convolves
    load_kernel(k_ident);
    fill_window("sel", c_123);
    bus.coeff_ld   = 1'b1;
    bus.coeff_sel  = 2'd3;
    bus.coeff_data = pack3(127, 127, 127);
    step();
    bus.coeff_ld = 1'b0;
    check("sel3.coeff_err", bus.coeff_err, 1);
    run_conv("sel3.bank_kept", 5, 0);
    bus.coeff_ld   = 1'b1;
    bus.coeff_sel  = 2'd1;
    bus.coeff_data = pack3(0, 2, 0);
    run_conv("same_cycle_ld.old_kernel", 5, 0);
    run_conv("same_cycle_ld.new_kernel", 10, 0);
    check("sel3.sticky", bus.coeff_err, 1);

    // Reset two cycles while a convolve is in flight
    bus.convolve_en = 1'b1;
    step();
    bus.convolve_en = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check_all_zero("mid_reset");
    for (int i = 0; i < 5; i++) begin
      step();
      check("mid_reset.no_valid", bus.result_valid, 0);
    end

    // Back-to-back convolves with same-cycle zero-column streams
    load_kernel(k_ones);
    fill_window("b2b", k_ones);
    busy_cnt = 0;
    first_v  = -1;
    last_v   = -1;
    bus.convolve_en   = 1'b1;
    bus.sample_stream = 1'b1;
    bus.sample_data   = '0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      step();
      if (cyc == 1) bus.sample_stream = 1'b0;
      if (cyc == 2) bus.convolve_en = 1'b0;
      if (bus.busy) busy_cnt++;
      if (bus.result_valid) begin
        res_q.push_back(int'(bus.result));
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
      end
    end
    check("b2b.busy_cycles", busy_cnt, 5);
    check("b2b.n_results", res_q.size(), 3);
    check("b2b.first_cycle", first_v, 2);
    check("b2b.last_cycle", last_v, 4);
    if (res_q.size() == 3) begin
      check("b2b.res0", res_q[0], 9);
      check("b2b.res1", res_q[1], 6);
      check("b2b.res2", res_q[2], 3);
    end

    // Stream beats shift when both are high
    load_kernel(k_ident);
    bus.row_clear = 1'b1;
    step();
    bus.row_clear = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.sample_stream = 1'b1;
      bus.sample_shift  = 1'b1;
      bus.sample_data   = c_123[i];
      step();
      check("prio.ready", bus.window_ready, (i == 2) ? 1 : 0);
    end
    clear_strobes();
    run_conv("prio.stream_wins", 5, 0);

    // Zero-column padding, saturation of the column count
    load_kernel(k_ones);
    bus.row_clear = 1'b1;
    step();
    bus.row_clear     = 1'b0;
    bus.sample_stream = 1'b1;
    bus.sample_data   = pack3(1, 1, 1);
    step();
    bus.sample_stream = 1'b0;
    bus.sample_shift  = 1'b1;
    step();
    check("pad.ready_two_cols", bus.window_ready, 0);
    step();
    bus.sample_shift = 1'b0;
    check("pad.ready", bus.window_ready, 1);
    run_conv("pad.result", 3, 0);
    bus.sample_shift = 1'b1;
    step();
    bus.sample_shift = 1'b0;
    check("pad.cnt_saturates", bus.window_ready, 1);

    // Clear wins over a same-cycle stream
    bus.row_clear     = 1'b1;
    bus.sample_stream = 1'b1;
    bus.sample_data   = pack3(5, 5, 5);
    step();
    clear_strobes();
    check("clear.ready", bus.window_ready, 0);
    run_conv("clear.result", 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
